// File: rtl/i_rotary_encoder.sv
// Purpose: quadrature decoder; one count pulse with direction per full detent cycle.
// Latency: o_cnt / o_cnt_err are registered, high for one cycle after the edge that sampled the completing/illegal phase.
// Backpressure: none; outputs are single-cycle pulses that downstream must consume on the next edge.
//
// Ports:
//   i_clk      system clock, all logic on the rising edge
//   i_rst      synchronous reset, active-high (state -> WAIT, outputs cleared)
//   i_phase_a  encoder phase A, already synchronous to i_clk
//   i_phase_b  encoder phase B, already synchronous to i_clk
//   o_cnt      one-cycle pulse: a full detent cycle completed
//   o_cnt_cw   direction of the most recent count (1 = clockwise), held between counts
//   o_cnt_err  one-cycle pulse: illegal two-bit phase jump detected

module i_rotary_encoder (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_phase_a,
  input  logic i_phase_b,
  output logic o_cnt,
  output logic o_cnt_cw,
  output logic o_cnt_err
);

  // Phase word P = {B,A}.
  localparam logic [1:0] P00 = 2'b00;
  localparam logic [1:0] P01 = 2'b01;
  localparam logic [1:0] P10 = 2'b10;
  localparam logic [1:0] P11 = 2'b11;

  // One state per position within a detent cycle. CWn / CCWn encode both
  // the current phase and the direction the cycle was entered from, so a
  // count is only possible after walking all four positions in order.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // expects 00
    ST_CW1  = 3'd1,  // 01
    ST_CW2  = 3'd2,  // 11
    ST_CW3  = 3'd3,  // 10
    ST_CCW1 = 3'd4,  // 10
    ST_CCW2 = 3'd5,  // 11
    ST_CCW3 = 3'd6,  // 01
    ST_WAIT = 3'd7   // lost track, resync on 00
  } state_t;

  // Power-on values match the reset values so the block behaves the same
  // whether or not reset is pulsed after configuration.
  state_t state  = ST_WAIT;
  logic   cnt_q  = 1'b0;
  logic   cw_q   = 1'b0;
  logic   err_q  = 1'b0;

  logic [1:0] phase;
  assign phase = {i_phase_b, i_phase_a};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Any partially walked cycle is dropped; tracking restarts at 00.
      state <= ST_WAIT;
      cnt_q <= 1'b0;
      cw_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      // Pulses default low so each assertion lasts exactly one cycle.
      cnt_q <= 1'b0;
      err_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          case (phase)
            P01: state <= ST_CW1;
            P10: state <= ST_CCW1;
            P11: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end

        ST_CW1: begin
          case (phase)
            P11: state <= ST_CW2;
            P00: state <= ST_IDLE;   // backstep
            P10: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_CW1;
          endcase
        end

        ST_CW2: begin
          case (phase)
            P10: state <= ST_CW3;
            P01: state <= ST_CW1;    // backstep
            P00: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_CW2;
          endcase
        end

        ST_CW3: begin
          case (phase)
            P00: begin
              // Direction is only ever updated together with a count.
              state <= ST_IDLE;
              cnt_q <= 1'b1;
              cw_q  <= 1'b1;
            end
            P11: state <= ST_CW2;    // backstep
            P01: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_CW3;
          endcase
        end

        ST_CCW1: begin
          case (phase)
            P11: state <= ST_CCW2;
            P00: state <= ST_IDLE;   // backstep
            P01: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_CCW1;
          endcase
        end

        ST_CCW2: begin
          case (phase)
            P01: state <= ST_CCW3;
            P10: state <= ST_CCW1;   // backstep
            P00: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_CCW2;
          endcase
        end

        ST_CCW3: begin
          case (phase)
            P00: begin
              state <= ST_IDLE;
              cnt_q <= 1'b1;
              cw_q  <= 1'b0;
            end
            P11: state <= ST_CCW2;   // backstep
            P10: begin
              state <= ST_WAIT;
              err_q <= 1'b1;
            end
            default: state <= ST_CCW3;
          endcase
        end

        // Silent while lost: no error pulses until the phases return to 00.
        ST_WAIT: begin
          if (phase == P00) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_WAIT;
      endcase
    end
  end

  assign o_cnt     = cnt_q;
  assign o_cnt_cw  = cw_q;
  assign o_cnt_err = err_q;

endmodule

// File: tb/tb_i_rotary_encoder.sv
module tb_i_rotary_encoder;

  logic i_clk;
  logic i_rst;
  logic i_phase_a;
  logic i_phase_b;
  logic o_cnt;
  logic o_cnt_cw;
  logic o_cnt_err;

  int tests;
  int fails;

  // Downstream consumer: 2-bit up/down counter fed by the pulses.
  logic [1:0] ext_ctr;

  // Expected direction flag carried across the hand-written sequences.
  bit model_cw;

  typedef struct {
    bit       rst;
    bit [1:0] p;      // {B,A}
    bit       cnt;
    bit       cw;
    bit       err;
    bit       chk_ctr;
    bit [1:0] ctr;
  } vec_t;

  vec_t tbl[$];

  i_rotary_encoder dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_phase_a (i_phase_a),
    .i_phase_b (i_phase_b),
    .o_cnt     (o_cnt),
    .o_cnt_cw  (o_cnt_cw),
    .o_cnt_err (o_cnt_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      ext_ctr <= 2'd0;
    else if (o_cnt)
      ext_ctr <= o_cnt_cw ? ext_ctr + 2'd1 : ext_ctr - 2'd1;
  end

  function automatic vec_t mk(bit r, bit [1:0] p, bit c, bit cw, bit e, bit cc, bit [1:0] ctr);
    vec_t v;
    v.rst = r; v.p = p; v.cnt = c; v.cw = cw; v.err = e; v.chk_ctr = cc; v.ctr = ctr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one phase word, let one rising edge sample it, check the
  // registered outputs produced by that edge.
  task automatic step(input bit r, input bit [1:0] p, input bit ec, input bit ecw,
                      input bit ee, input string name);
    i_rst     = r;
    i_phase_b = p[1];
    i_phase_a = p[0];
    @(posedge i_clk);
    #1;
    chk({name, ".cnt"}, int'(o_cnt), int'(ec));
    chk({name, ".cw"},  int'(o_cnt_cw), int'(ecw));
    chk({name, ".err"}, int'(o_cnt_err), int'(ee));
  endtask

  // One full detent cycle with every phase held for 'hold' clocks.
  task automatic slow_cycle(input bit cw, input int hold, input string name);
    bit [1:0] seq [4];
    bit c;
    if (cw) begin
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    end else begin
      seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    end
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < hold; r++) begin
        c = (s == 3) && (r == 0);
        if (c) model_cw = cw;
        step(1'b0, seq[s], c, model_cw, 1'b0, $sformatf("%s.s%0d.r%0d", name, s, r));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    i_rst = 1'b1;
    i_phase_a = 1'b0;
    i_phase_b = 1'b0;

    // Reset state, then idle 00.
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
    // Three fast clockwise cycles.
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 2'b01, 0, (k > 0), 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b11, 0, (k > 0), 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b10, 0, (k > 0), 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b00, 1, 1, 0, 0, 2'd0));
    end
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 1, 2'd3));
    // Three fast counterclockwise cycles.
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 2'b10, 0, (k == 0), 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b11, 0, (k == 0), 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b01, 0, (k == 0), 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b00, 1, 0, 0, 0, 2'd0));
    end
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 2'd0));
    // Separate pulses and back-and-forth, three times: never a count.
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
    end
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 2'd0));
    // Two-bit jumps; WAIT stays silent until 00.
    tbl.push_back(mk(0, 2'b11, 0, 0, 1, 0, 2'd0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 1, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 1, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 2'd0));
    // Clean clockwise cycle after the errors counts normally.
    tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 1, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 1, 2'd1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].p, tbl[i].cnt, tbl[i].cw, tbl[i].err, $sformatf("vec%0d", i));
      if (tbl[i].chk_ctr)
        chk($sformatf("vec%0d.ctr", i), int'(ext_ctr), int'(tbl[i].ctr));
    end

    // Slow cycles, each phase held 11 clocks.
    model_cw = 1'b1;
    for (int k = 0; k < 3; k++) slow_cycle(1'b1, 11, $sformatf("slow_cw%0d", k));
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "slow_cw_tail");
    chk("slow_cw.ctr", int'(ext_ctr), 0);
    for (int k = 0; k < 3; k++) slow_cycle(1'b0, 11, $sformatf("slow_ccw%0d", k));
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "slow_ccw_tail");
    chk("slow_ccw.ctr", int'(ext_ctr), 1);

    // Reset in the middle of a clockwise cycle.
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "mid.a");
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "mid.b");
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "mid.rst");
    step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "mid.c");
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "mid.d");
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "mid.e");
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "mid.f");
    step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "mid.g");
    step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, "mid.h");
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "mid.i");
    chk("mid.ctr", int'(ext_ctr), 1);

    // Reset clears the direction flag, and tracking waits for 00 before
    // accepting a cycle: the first cycle after release is ignored.
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "rw.rst");
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "rw.a");
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "rw.b");
    step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "rw.c");
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "rw.d");
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "rw.e");
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "rw.f");
    step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "rw.g");
    step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, "rw.h");
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "rw.i");
    chk("rw.ctr", int'(ext_ctr), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
